// File: rtl/regfile_xfer_controller.sv
// regfile_xfer_controller
// Purpose : initiator side of the R0-R15 register file port. Accepts MOVE,
//           LOADI, READ and SWAP commands over a valid/ready handshake and
//           sequences them into register-file read and write cycles.
// Latency : cycles from accept edge back to IDLE: LOADI 1, MOVE 2, READ 2, SWAP 4.
// Backpr. : req_ready is high only in IDLE, so there is at least one IDLE cycle
//           between commands. A command held on req_valid waits until then.
//
// Ports
//   clk, reset           clock, asynchronous active-high reset
//   req_valid/req_ready  command handshake; req_op/src/dst/imm are latched on accept
//   rf_addr_in/rf_load/rf_data_in        register-file write port
//   rf_addr_out/rf_enable_out/rf_data_out register-file read port
//   rd_valid/rd_data     READ result (rd_data holds between READs)
//   done                 one-cycle pulse when any command completes
module regfile_xfer_controller #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 4
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  req_valid,
   output logic                  req_ready,
   input  logic [1:0]            req_op,
   input  logic [ADDR_WIDTH-1:0] req_src,
   input  logic [ADDR_WIDTH-1:0] req_dst,
   input  logic [DATA_WIDTH-1:0] req_imm,
   output logic [ADDR_WIDTH-1:0] rf_addr_in,
   output logic [ADDR_WIDTH-1:0] rf_addr_out,
   output logic                  rf_load,
   output logic                  rf_enable_out,
   output logic [DATA_WIDTH-1:0] rf_data_in,
   input  logic [DATA_WIDTH-1:0] rf_data_out,
   output logic                  rd_valid,
   output logic [DATA_WIDTH-1:0] rd_data,
   output logic                  done
);

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      RD_A = 3'd1,
      RD_B = 3'd2,
      WR_A = 3'd3,
      WR_B = 3'd4,
      RESP = 3'd5
   } state_t;

   localparam logic [1:0] OP_MOVE  = 2'b00;
   localparam logic [1:0] OP_LOADI = 2'b01;
   localparam logic [1:0] OP_READ  = 2'b10;
   localparam logic [1:0] OP_SWAP  = 2'b11;

   state_t                state, state_nxt;
   logic [1:0]            op_q;
   logic [ADDR_WIDTH-1:0] src_q;
   logic [ADDR_WIDTH-1:0] dst_q;
   logic [DATA_WIDTH-1:0] imm_q;
   logic [DATA_WIDTH-1:0] tmp_a;     // value read from Rs
   logic [DATA_WIDTH-1:0] tmp_b;     // value read from Rd (SWAP only)
   logic [DATA_WIDTH-1:0] rd_data_q; // last READ result, survives other commands
   logic                  accept;

   // req_ready depends on state only, so accept never forms a loop through req_valid.
   assign accept = (state == IDLE) && req_valid;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state     <= IDLE;
         op_q      <= '0;
         src_q     <= '0;
         dst_q     <= '0;
         imm_q     <= '0;
         tmp_a     <= '0;
         tmp_b     <= '0;
         rd_data_q <= '0;
      end else begin
         state <= state_nxt;
         if (accept) begin
            op_q  <= req_op;
            src_q <= req_src;
            dst_q <= req_dst;
            imm_q <= req_imm;
         end
         if (state == RD_A) begin
            tmp_a <= rf_data_out;
         end
         // Capture the READ result separately: tmp_a is reused by MOVE/SWAP
         // and rd_data has to keep the previous READ value across them.
         if ((state == RD_A) && (op_q == OP_READ)) begin
            rd_data_q <= rf_data_out;
         end
         if (state == RD_B) begin
            tmp_b <= rf_data_out;
         end
      end
   end

   // Next-state decode
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: begin
            if (accept) begin
               case (req_op)
                  OP_LOADI: state_nxt = WR_B;
                  default:  state_nxt = RD_A;   // MOVE, READ, SWAP all read Rs first
               endcase
            end
         end
         RD_A: begin
            case (op_q)
               OP_READ: state_nxt = RESP;
               OP_SWAP: state_nxt = RD_B;
               default: state_nxt = WR_B;
            endcase
         end
         RD_B:    state_nxt = WR_A;
         WR_A:    state_nxt = WR_B;
         WR_B:    state_nxt = IDLE;
         RESP:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Output decode: every output comes from the state and latched registers,
   // and idle buses are forced to zero.
   always_comb begin
      req_ready     = 1'b0;
      rf_addr_in    = '0;
      rf_addr_out   = '0;
      rf_load       = 1'b0;
      rf_enable_out = 1'b0;
      rf_data_in    = '0;
      rd_valid      = 1'b0;
      done          = 1'b0;
      case (state)
         IDLE: begin
            req_ready = 1'b1;
         end
         RD_A: begin
            rf_enable_out = 1'b1;
            rf_addr_out   = src_q;
         end
         RD_B: begin
            rf_enable_out = 1'b1;
            rf_addr_out   = dst_q;
         end
         WR_A: begin
            rf_load    = 1'b1;
            rf_addr_in = src_q;
            rf_data_in = tmp_b;
         end
         WR_B: begin
            rf_load    = 1'b1;
            rf_addr_in = dst_q;
            rf_data_in = (op_q == OP_LOADI) ? imm_q : tmp_a;
            done       = 1'b1;
         end
         RESP: begin
            rd_valid = 1'b1;
            done     = 1'b1;
         end
         default: begin
            req_ready = 1'b0;
         end
      endcase
   end

   assign rd_data = rd_data_q;

endmodule

// File: tb/tb_regfile_xfer_controller.sv
// Bench for regfile_xfer_controller: behavioural register file, table of
// directed vectors, randomized commands against a command-level model,
// plus reset-mid-SWAP and back-to-back sequences.
module tb_regfile_xfer_controller;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        req_valid = 1'b0;
   logic        req_ready;
   logic [1:0]  req_op = 2'b00;
   logic [3:0]  req_src = 4'd0;
   logic [3:0]  req_dst = 4'd0;
   logic [31:0] req_imm = 32'd0;
   logic [3:0]  rf_addr_in, rf_addr_out;
   logic        rf_load, rf_enable_out;
   logic [31:0] rf_data_in, rf_data_out;
   logic        rd_valid;
   logic [31:0] rd_data;
   logic        done;

   always #5 clk = ~clk;

   regfile_xfer_controller #(.DATA_WIDTH(32), .ADDR_WIDTH(4)) dut (
      .clk(clk), .reset(reset),
      .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
      .req_src(req_src), .req_dst(req_dst), .req_imm(req_imm),
      .rf_addr_in(rf_addr_in), .rf_addr_out(rf_addr_out),
      .rf_load(rf_load), .rf_enable_out(rf_enable_out),
      .rf_data_in(rf_data_in), .rf_data_out(rf_data_out),
      .rd_valid(rd_valid), .rd_data(rd_data), .done(done)
   );

   // Behavioural register file; drives a junk pattern when not enabled so
   // any capture at the wrong time is visible.
   logic [31:0] rf [16];
   assign rf_data_out = rf_enable_out ? rf[rf_addr_out] : 32'hBAD0_BAD0;
   always @(posedge clk) begin
      if (rf_load) rf[rf_addr_in] = rf_data_in;
   end

   int ncmp = 0;
   int nfail = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      ncmp++;
      if (act !== exp) begin
         nfail++;
         $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Bus invariants, every cycle away from the edge.
   always @(negedge clk) begin
      if (!reset) begin
         chk("load_and_enable", 32'(rf_load & rf_enable_out), 32'd0);
         if (!rf_enable_out) chk("addr_out_idle", 32'(rf_addr_out), 32'd0);
         if (!rf_load) begin
            chk("addr_in_idle", 32'(rf_addr_in), 32'd0);
            chk("data_in_idle", rf_data_in, 32'd0);
         end
      end
   end

   // Command-level reference state
   logic [31:0] model_rf [16];
   logic [31:0] last_rd = 32'd0;

   // Observations of one command
   int          obs_lat, obs_nrd, obs_nwr;
   logic [3:0]  obs_rda [4];
   logic [3:0]  obs_wa  [4];
   logic [31:0] obs_wd  [4];
   logic        obs_rdv;
   logic [31:0] obs_rdd;

   task automatic run_cmd(input logic [1:0] op, input logic [3:0] src, input logic [3:0] dst,
                          input logic [31:0] imm);
      int  cyc;
      bit  fin;
      @(negedge clk);
      req_valid = 1'b1; req_op = op; req_src = src; req_dst = dst; req_imm = imm;
      chk("ready_before", 32'(req_ready), 32'd1);
      @(posedge clk);
      @(negedge clk);
      // scramble inputs: the command must already be latched
      req_valid = 1'b0; req_op = 2'($urandom); req_src = 4'($urandom);
      req_dst = 4'($urandom); req_imm = $urandom;
      obs_nrd = 0; obs_nwr = 0; obs_rdv = 1'b0; obs_rdd = 32'd0; obs_lat = 0;
      cyc = 1; fin = 1'b0;
      while (!fin && cyc <= 8) begin
         if (rf_enable_out && obs_nrd < 4) begin obs_rda[obs_nrd] = rf_addr_out; obs_nrd++; end
         if (rf_load && obs_nwr < 4) begin
            obs_wa[obs_nwr] = rf_addr_in; obs_wd[obs_nwr] = rf_data_in; obs_nwr++;
         end
         if (rd_valid) begin obs_rdv = 1'b1; obs_rdd = rd_data; end
         chk("ready_busy", 32'(req_ready), 32'd0);
         if (done) begin
            fin = 1'b1; obs_lat = cyc;
         end else begin
            @(negedge clk);
            cyc++;
         end
      end
      if (!fin) chk("done_timeout", 32'd0, 32'd1);
      @(negedge clk);
      chk("ready_after", 32'(req_ready), 32'd1);
   endtask

   // Model: predict bus activity and register effect from the command rules.
   task automatic check_cmd(input logic [1:0] op, input logic [3:0] src, input logic [3:0] dst,
                            input logic [31:0] imm);
      int          elat, enrd, enwr;
      logic [3:0]  erd [2];
      logic [3:0]  ewa [2];
      logic [31:0] ewd [2];
      logic [31:0] vs, vd;
      vs = model_rf[src]; vd = model_rf[dst];
      enrd = 0; enwr = 0; elat = 0;
      erd[0] = 4'd0; erd[1] = 4'd0; ewa[0] = 4'd0; ewa[1] = 4'd0; ewd[0] = 32'd0; ewd[1] = 32'd0;
      case (op)
         2'b00: begin elat = 2; enrd = 1; erd[0] = src; enwr = 1; ewa[0] = dst; ewd[0] = vs; end
         2'b01: begin elat = 1; enwr = 1; ewa[0] = dst; ewd[0] = imm; end
         2'b10: begin elat = 2; enrd = 1; erd[0] = src; end
         default: begin
            elat = 4; enrd = 2; erd[0] = src; erd[1] = dst;
            enwr = 2; ewa[0] = src; ewd[0] = vd; ewa[1] = dst; ewd[1] = vs;
         end
      endcase
      run_cmd(op, src, dst, imm);
      chk("latency", 32'(obs_lat), 32'(elat));
      chk("num_reads", 32'(obs_nrd), 32'(enrd));
      chk("num_writes", 32'(obs_nwr), 32'(enwr));
      for (int i = 0; i < enrd; i++)
         if (i < obs_nrd) chk("read_addr", 32'(obs_rda[i]), 32'(erd[i]));
      for (int i = 0; i < enwr; i++)
         if (i < obs_nwr) begin
            chk("write_addr", 32'(obs_wa[i]), 32'(ewa[i]));
            chk("write_data", obs_wd[i], ewd[i]);
         end
      chk("rd_valid_seen", 32'(obs_rdv), 32'(op == 2'b10));
      if (op == 2'b10) begin
         chk("rd_data_pulse", obs_rdd, vs);
         last_rd = vs;
      end
      for (int i = 0; i < enwr; i++) model_rf[ewa[i]] = ewd[i];
      chk("rf_src_after", rf[src], model_rf[src]);
      chk("rf_dst_after", rf[dst], model_rf[dst]);
      chk("rd_data_hold", rd_data, last_rd);
   endtask

   typedef struct {
      logic [1:0]  op;
      logic [3:0]  src, dst;
      logic [31:0] imm, pre_s, pre_d;
      int          lat;
      logic [31:0] exp_s, exp_d;
      logic        rdv;
      logic [31:0] exp_rd;
   } vec_t;

   vec_t vecs [8];

   int          t_acc [3];
   logic [1:0]  b_op  [3];
   logic [3:0]  b_src [3];
   logic [3:0]  b_dst [3];
   logic [31:0] b_imm [3];

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, required finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int loads;
      int k;
      bit saw;
      for (int i = 0; i < 16; i++) begin rf[i] = 32'd0; model_rf[i] = 32'd0; end

      //        op     src   dst   imm           pre_s         pre_d         lat exp_s         exp_d         rdv   exp_rd
      vecs[0] = '{2'b01, 4'd0, 4'd3, 32'hDEADBEEF, 32'h0,        32'h0,        1, 32'h0,        32'hDEADBEEF, 1'b0, 32'h0};
      vecs[1] = '{2'b00, 4'd1, 4'd7, 32'h0,        32'h11,       32'h77,       2, 32'h11,       32'h11,       1'b0, 32'h0};
      vecs[2] = '{2'b10, 4'd2, 4'd5, 32'h0,        32'hA5A5A5A5, 32'h55,       2, 32'hA5A5A5A5, 32'h55,       1'b1, 32'hA5A5A5A5};
      vecs[3] = '{2'b11, 4'd4, 4'd9, 32'h0,        32'h4,        32'h9,        4, 32'h9,        32'h4,        1'b0, 32'h0};
      vecs[4] = '{2'b11, 4'd6, 4'd6, 32'h0,        32'h66,       32'h66,       4, 32'h66,       32'h66,       1'b0, 32'h0};
      vecs[5] = '{2'b00, 4'd8, 4'd8, 32'h0,        32'h88,       32'h88,       2, 32'h88,       32'h88,       1'b0, 32'h0};
      vecs[6] = '{2'b01, 4'd0, 4'd15, 32'h0,       32'h0,        32'hFFFFFFFF, 1, 32'h0,        32'h0,        1'b0, 32'h0};
      vecs[7] = '{2'b10, 4'd0, 4'd1, 32'h0,        32'h0,        32'h11,       2, 32'h0,        32'h11,       1'b1, 32'h0};

      // Reset state
      repeat (2) @(negedge clk);
      chk("rst_ready", 32'(req_ready), 32'd1);
      chk("rst_load", 32'(rf_load), 32'd0);
      chk("rst_enable", 32'(rf_enable_out), 32'd0);
      chk("rst_rd_valid", 32'(rd_valid), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_rd_data", rd_data, 32'd0);
      reset = 1'b0;

      // Directed table
      for (int v = 0; v < 8; v++) begin
         rf[vecs[v].src] = vecs[v].pre_s; model_rf[vecs[v].src] = vecs[v].pre_s;
         rf[vecs[v].dst] = vecs[v].pre_d; model_rf[vecs[v].dst] = vecs[v].pre_d;
         check_cmd(vecs[v].op, vecs[v].src, vecs[v].dst, vecs[v].imm);
         chk("vec_latency", 32'(obs_lat), 32'(vecs[v].lat));
         chk("vec_src", rf[vecs[v].src], vecs[v].exp_s);
         chk("vec_dst", rf[vecs[v].dst], vecs[v].exp_d);
         chk("vec_rdv", 32'(obs_rdv), 32'(vecs[v].rdv));
         if (vecs[v].rdv) chk("vec_rd_data", obs_rdd, vecs[v].exp_rd);
      end

      // Reset during RD_B of a SWAP
      rf[4] = 32'h4; model_rf[4] = 32'h4; rf[9] = 32'h9; model_rf[9] = 32'h9;
      @(negedge clk);
      req_valid = 1'b1; req_op = 2'b11; req_src = 4'd4; req_dst = 4'd9;
      @(posedge clk); @(negedge clk);
      req_valid = 1'b0;
      @(negedge clk);
      chk("swp_rdb_enable", 32'(rf_enable_out), 32'd1);
      chk("swp_rdb_addr", 32'(rf_addr_out), 32'd9);
      reset = 1'b1;
      #1;
      chk("mid_rst_enable", 32'(rf_enable_out), 32'd0);
      chk("mid_rst_addr_out", 32'(rf_addr_out), 32'd0);
      chk("mid_rst_load", 32'(rf_load), 32'd0);
      chk("mid_rst_ready", 32'(req_ready), 32'd1);
      chk("mid_rst_rd_data", rd_data, 32'd0);
      last_rd = 32'd0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
      loads = 0;
      repeat (6) begin
         @(negedge clk);
         if (rf_load) loads++;
      end
      chk("post_rst_loads", 32'(loads), 32'd0);
      chk("post_rst_r4", rf[4], 32'h4);
      chk("post_rst_r9", rf[9], 32'h9);

      // Back-to-back with req_valid held high: LOADI R10, MOVE R10->R11, READ R11
      b_op[0] = 2'b01; b_src[0] = 4'd0;  b_dst[0] = 4'd10; b_imm[0] = 32'h1234;
      b_op[1] = 2'b00; b_src[1] = 4'd10; b_dst[1] = 4'd11; b_imm[1] = 32'h0;
      b_op[2] = 2'b10; b_src[2] = 4'd11; b_dst[2] = 4'd0;  b_imm[2] = 32'h0;
      // accept k+1 comes one IDLE cycle after command k finishes
      t_acc[0] = 0; t_acc[1] = 0 + 1 + 1; t_acc[2] = t_acc[1] + 2 + 1;
      k = 0; saw = 1'b0;
      @(negedge clk);
      req_valid = 1'b1; req_op = b_op[0]; req_src = b_src[0]; req_dst = b_dst[0]; req_imm = b_imm[0];
      for (int c = 0; c < t_acc[2] + 3; c++) begin
         chk("b2b_ready", 32'(req_ready), 32'(k < 3 && c == t_acc[k < 3 ? k : 0]));
         if (rd_valid) begin saw = 1'b1; chk("b2b_rd_data", rd_data, 32'h1234); end
         @(posedge clk); @(negedge clk);
         if (k < 3 && c == t_acc[k]) begin
            k++;
            if (k < 3) begin
               req_op = b_op[k]; req_src = b_src[k]; req_dst = b_dst[k]; req_imm = b_imm[k];
            end else begin
               req_valid = 1'b0;
            end
         end
      end
      req_valid = 1'b0;
      chk("b2b_rd_seen", 32'(saw), 32'd1);
      chk("b2b_r10", rf[10], 32'h1234);
      chk("b2b_r11", rf[11], 32'h1234);
      model_rf[10] = 32'h1234; model_rf[11] = 32'h1234; last_rd = 32'h1234;

      // Randomized commands against the model
      for (int n = 0; n < 200; n++) begin
         check_cmd(2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)),
                   4'($urandom_range(0, 15)), $urandom);
      end
      for (int i = 0; i < 16; i++) chk("final_rf", rf[i], model_rf[i]);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
      $finish;
   end

endmodule
